bist_engine: RTL

Parametrised built-in self-test engine wrapping one external combinational circuit-under-test (CUT). In functional mode it passes primary inputs straight to the CUT. On `start` it:
- drives the CUT from an internal LFSR pattern generator for a programmable number of patterns,
- compresses the CUT responses into a multiple-input signature register (MISR),
- compares the final signature against a golden value and reports pass/fail.

It replaces the fixed 3-input pattern-generator / mux / signature / comparator arrangement with one controller of configurable width, depth and signature length.

---
 rtl/bist_engine_if.sv | 25 ++
 rtl/bist_engine.sv | 114 +++++++++++
 2 files changed

// File: rtl/bist_engine_if.sv
// Control/status interface of the BIST engine.
//   start, abort           : test request and cancel (driven by the master)
//   busy, done, pass, fail : engine status (driven by the engine)
//   signature              : current MISR contents
interface bist_engine_if #(
  parameter int SIG_W = 4
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, abort,
    input  busy, done, pass, fail, signature
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, fail, signature
  );
endinterface

// File: rtl/bist_engine.sv
// Built-in self-test engine around one combinational CUT.
// In functional mode func_in passes straight to cut_in. On an accepted start
// an LFSR drives N_PATTERNS patterns into the CUT, a MISR compresses the
// responses, and the final signature is compared against GOLDEN_SIG.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   ctl     : control/status interface (start, abort, busy, done, pass, fail, signature)
//   func_in : functional-mode CUT inputs
//   cut_in  : CUT input drive (LFSR during APPLY, func_in otherwise)
//   cut_out : CUT response
module bist_engine #(
  parameter int                N_IN       = 3,
  parameter int                N_OUT      = 1,
  parameter int                SIG_W      = 4,
  parameter int                N_PATTERNS = 7,
  parameter logic [N_IN-1:0]   LFSR_POLY  = 3'b110,
  parameter logic [N_IN-1:0]   LFSR_SEED  = 3'b001,
  parameter logic [SIG_W-1:0]  SIG_POLY   = 4'b0011,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  bist_engine_if.slave     ctl,
  input  logic [N_IN-1:0]  func_in,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out
);

  localparam int              CNT_W = $clog2(N_PATTERNS + 1);
  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [N_IN-1:0]  SEED  = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  lfsr;
  logic [SIG_W-1:0] misr, misr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pass_q, fail_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctl.start) state_nxt = APPLY;
      APPLY:   if (cnt == LAST) state_nxt = COMPARE;
      COMPARE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ctl.abort) state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    ctl.busy = (state == APPLY) || (state == COMPARE);
    ctl.done = (state == DONE) && !ctl.abort;
    cut_in   = (state == APPLY) ? lfsr : func_in;
  end

  always_comb begin
    misr_nxt = {misr[SIG_W-2:0], 1'b0}
             ^ (misr[SIG_W-1] ? SIG_POLY : '0)
             ^ SIG_W'(cut_out);
  end

  // Datapath: LFSR, MISR, pattern counter and sticky result flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr   <= SEED;
      misr   <= '0;
      cnt    <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (ctl.abort) begin
      // LFSR and MISR hold so the partial signature stays observable
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctl.start) begin
          lfsr   <= SEED;
          misr   <= '0;
          cnt    <= '0;
          pass_q <= 1'b0;
          fail_q <= 1'b0;
        end
        APPLY: begin
          misr <= misr_nxt;
          lfsr <= {lfsr[N_IN-2:0], ^(lfsr & LFSR_POLY)};
          cnt  <= cnt + CNT_W'(1);
        end
        COMPARE: begin
          pass_q <= (misr == GOLDEN_SIG);
          fail_q <= (misr != GOLDEN_SIG);
        end
        default: ;
      endcase
    end
  end

  assign ctl.pass      = pass_q;
  assign ctl.fail      = fail_q;
  assign ctl.signature = misr;

endmodule
